// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: datapath width, instruction size,
// default reset PC and the queue entry layout.
`timescale 1ns/1ps
package fetch_unit_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            filled;
  } entry_t;

  // Sequential fetch address; wraps naturally at 32 bits.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// In-order instruction queue of the fetch stage: entries are allocated on grant,
// filled by in-order responses and popped by decode; flush empties it.
`timescale 1ns/1ps
module fetch_unit_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_data,
  output logic            head_filled,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   pending
);

  entry_t        entries [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] fill_ptr;

  // Fill always lags allocation, so tail and fill_ptr never collide while a
  // fill and an allocation happen together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pending  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pending  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        entries[tail] <= '{pc: alloc_pc, data: '0, filled: 1'b0};
        tail          <= tail + AW'(1);
      end
      if (fill) begin
        entries[fill_ptr].data   <= fill_data;
        entries[fill_ptr].filled <= 1'b1;
        fill_ptr                 <= fill_ptr + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      count   <= count + CW'(alloc) - CW'(pop);
      pending <= pending + CW'(alloc) - CW'(fill);
    end
  end

  assign head_pc     = entries[head].pc;
  assign head_data   = entries[head].data;
  assign head_filled = entries[head].filled;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, instruction-memory request/discard logic and the fetch queue.
// Optional misaligned-redirect check is enabled with FETCH_MISALIGN_CHK_EN.
`timescale 1ns/1ps
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_is_branching,
  input  logic [XLEN-1:0] i_branch_addr,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic            o_misaligned
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW-1:0]   pending;
  logic [CW:0]     occupancy;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_data;
  logic            head_filled;
  logic            grant;
  logic            pop;
  logic            fill;
  logic            blocked;

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               o_misaligned <= 1'b0;
    else if (i_is_branching) o_misaligned <= |i_branch_addr[1:0];
  end
  assign blocked = o_misaligned;
`else
  assign blocked = 1'b0;
`endif

  // Responses still owed for flushed requests count against queue capacity.
  assign occupancy = {1'b0, count} + {1'b0, discard};

  always_comb begin
    o_imem_req = !i_rst && (count < DEPTH_C) && (occupancy < {1'b0, DEPTH_C})
                 && !i_is_branching && !blocked;
    o_instr_valid = head_filled && (count != '0) && !i_is_branching;
    grant = o_imem_req && i_imem_gnt;
    pop   = o_instr_valid && i_instr_ready;
    fill  = i_imem_rvalid && (discard == '0) && !i_is_branching;
  end

  assign o_imem_addr = pc;
  assign o_instr     = head_data;
  assign o_instr_pc  = head_pc;

  // A redirect turns every outstanding unfilled request into a discard,
  // except a response arriving in the redirect cycle, which is dropped there.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc      <= RESET_PC;
      discard <= '0;
    end else if (i_is_branching) begin
      pc      <= i_branch_addr;
      discard <= discard + pending - CW'(i_imem_rvalid);
    end else begin
      if (grant) pc <= next_pc(pc);
      if (i_imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
    end
  end

  fetch_unit_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (i_clk),
    .rst         (i_rst),
    .flush       (i_is_branching),
    .alloc       (grant),
    .alloc_pc    (pc),
    .fill        (fill),
    .fill_data   (i_imem_rdata),
    .pop         (pop),
    .head_pc     (head_pc),
    .head_data   (head_data),
    .head_filled (head_filled),
    .count       (count),
    .pending     (pending)
  );

endmodule
